// File: rtl/cmp_sequencer.sv
// rtl/cmp_sequencer.sv - bitmap compare sequencer: loads 64x24 rows, feeds column/top/bottom slices to the compare ALU.
module cmp_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        mem_rd,
    output logic [5:0]  mem_addr,
    input  logic [23:0] mem_rdata,
    output logic        alu_start,
    output logic [63:0] alu_col,
    output logic [23:0] alu_rowtop,
    output logic [23:0] alu_rowbot,
    output logic        alu_colready,
    output logic        alu_rowtopready,
    output logic        alu_rowbotready,
    output logic        alu_lastcol,
    input  logic        alu_nextcol,
    input  logic        alu_nextrowtop,
    input  logic        alu_nextrowbot,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_FEED,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    // Stream slots: 0 = column, 1 = top rows, 2 = bottom rows (counted up, mapped to 63..32).
    localparam logic [2:0][4:0] LAST_IDX = {5'd31, 5'd31, 5'd23};
    localparam logic [7:0]      TO_CNT   = 8'(TIMEOUT);

    state_t          state_q, state_d;
    logic [6:0]      lcnt_q, lcnt_d;
    logic            cap_vld_q;
    logic [5:0]      cap_addr_q;
    logic [23:0]     buf_q [64];
    logic [2:0][1:0] ph_q, ph_d;
    logic [2:0][4:0] idx_q, idx_d;
    logic [2:0]      cmp_q, cmp_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [15:0]     result_q, result_d;
    logic [2:0]      rdy;
    logic [2:0]      next_flag;

    assign next_flag = {alu_nextrowbot, alu_nextrowtop, alu_nextcol};

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        cmp_d     = cmp_q;
        wcnt_d    = wcnt_q;
        result_d  = result_q;
        mem_rd    = 1'b0;
        alu_start = 1'b0;
        rdy       = 3'b000;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOAD;
                    lcnt_d  = '0;
                end
            end
            S_LOAD: begin
                if (lcnt_q == 7'd64) begin
                    state_d = S_INIT;
                end else begin
                    mem_rd = 1'b1;
                    lcnt_d = lcnt_q + 7'd1;
                end
            end
            S_INIT: begin
                alu_start = 1'b1;
                ph_d      = '0;
                idx_d     = '0;
                cmp_d     = '0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                // Per stream: issue (ready pulse), two guard cycles, then wait for the ALU flag.
                for (int s = 0; s < 3; s++) begin
                    if (!cmp_q[s]) begin
                        case (ph_q[s])
                            2'd0: begin
                                rdy[s]  = 1'b1;
                                ph_d[s] = 2'd1;
                            end
                            2'd1: ph_d[s] = 2'd2;
                            2'd2: ph_d[s] = 2'd3;
                            default: begin
                                if (next_flag[s]) begin
                                    ph_d[s] = 2'd0;
                                    if (idx_q[s] == LAST_IDX[s]) begin
                                        cmp_d[s] = 1'b1;
                                    end else begin
                                        idx_d[s] = idx_q[s] + 5'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                if (&cmp_d) begin
                    state_d = S_WAIT_DONE;
                    wcnt_d  = '0;
                end
            end
            S_WAIT_DONE: begin
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = S_FINISH;
                end else if (wcnt_q == TO_CNT) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lcnt_q   <= '0;
            ph_q     <= '0;
            idx_q    <= '0;
            cmp_q    <= '0;
            wcnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lcnt_q   <= lcnt_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            cmp_q    <= cmp_d;
            wcnt_q   <= wcnt_d;
            result_q <= result_d;
        end
    end

    // Read data returns one cycle after the strobe, so remember which row it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
        end else begin
            cap_vld_q  <= mem_rd;
            cap_addr_q <= mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_vld_q) begin
            buf_q[cap_addr_q] <= mem_rdata;
        end
    end

    always_comb begin
        alu_col = '0;
        for (int r = 0; r < 64; r++) begin
            alu_col[r] = buf_q[r][5'd23 - idx_q[0]];
        end
    end

    assign alu_rowtop      = buf_q[{1'b0, idx_q[1]}];
    assign alu_rowbot      = buf_q[6'd63 - {1'b0, idx_q[2]}];
    assign alu_colready    = rdy[0];
    assign alu_rowtopready = rdy[1];
    assign alu_rowbotready = rdy[2];
    assign alu_lastcol     = (state_q == S_FEED) && (idx_q[0] == 5'd23);
    assign mem_addr        = lcnt_q[5:0];
    assign busy            = (state_q != S_IDLE);
    assign result          = result_q;

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb/tb_cmp_sequencer.sv - randomized bench for cmp_sequencer with a memory/ALU responder and slice reference model.
module tb_cmp_sequencer;

    logic        clk = 1'b0;
    logic        rst, req, mem_rd, alu_start;
    logic [5:0]  mem_addr;
    logic [23:0] mem_rdata, alu_rowtop, alu_rowbot;
    logic [63:0] alu_col;
    logic        alu_colready, alu_rowtopready, alu_rowbotready, alu_lastcol;
    logic        alu_nextcol, alu_nextrowtop, alu_nextrowbot, alu_done;
    logic [15:0] alu_result, result;
    logic        busy, done, err;

    cmp_sequencer #(.TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req(req),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .alu_start(alu_start), .alu_col(alu_col), .alu_rowtop(alu_rowtop), .alu_rowbot(alu_rowbot),
        .alu_colready(alu_colready), .alu_rowtopready(alu_rowtopready), .alu_rowbotready(alu_rowbotready),
        .alu_lastcol(alu_lastcol),
        .alu_nextcol(alu_nextcol), .alu_nextrowtop(alu_nextrowtop), .alu_nextrowbot(alu_nextrowbot),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [64];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_result = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_alu_start"}, alu_start, 0);
        chk({tag, "_ready"}, {alu_rowbotready, alu_rowtopready, alu_colready}, 0);
        chk({tag, "_lastcol"}, alu_lastcol, 0);
        chk({tag, "_result"}, result, exp_result);
    endtask

    task automatic fill_mem(input bit special);
        for (int r = 0; r < 64; r++) mem[r] = special ? ((r == 10) ? 24'h000800 : 24'h0) : 24'($urandom);
    endtask

    function automatic logic [63:0] exp_slice(input int s, input int i);
        logic [63:0] e = '0;
        case (s)
            0: for (int r = 0; r < 64; r++) e[r] = mem[r][23 - i];
            1: e = {40'h0, mem[i]};
            default: e = {40'h0, mem[63 - i]};
        endcase
        return e;
    endfunction

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            {alu_nextcol, alu_nextrowtop, alu_nextrowbot} = 3'b000;
            alu_done = 1'($urandom_range(0, 1));
            alu_result = 16'($urandom);
            mem_rdata = 24'($urandom);
            #1;
            chk_quiet("idle");
        end
    endtask

    // dd: cycles into WAIT_DONE at which alu_done rises (-1 = never); abort_* plant a reset.
    task automatic run_job(input int ack_max, input int dd, input logic [15:0] res, input bit hold_req,
                           input int abort_col, input int abort_cyc, input bit special);
        int n[3], nxt[3], ackc[3], fin[3];
        int lastn[3];
        int w, d;
        bit prev_rd, abort_next, in_feed, exp_done, exp_err;
        logic [5:0]  prev_addr;
        logic [2:0]  rdy_obs;
        logic [63:0] obs;
        lastn = '{23, 31, 31};
        for (int s = 0; s < 3; s++) begin
            n[s] = 0; nxt[s] = 67; ackc[s] = -1; fin[s] = -1;
        end
        w = -1; prev_rd = 0; prev_addr = '0; abort_next = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (abort_next || cyc == abort_cyc) begin
                rst = 1'b1; req = 1'b0; alu_done = 1'b0;
                {alu_nextcol, alu_nextrowtop, alu_nextrowbot} = 3'b000;
                @(posedge clk);
                #1;
                rst = 1'b0;
                #1;
                exp_result = '0;
                chk_quiet("after_rst");
                return;
            end
            req = (cyc == 0 || hold_req) ? 1'b1 : 1'($urandom_range(0, 1));
            alu_nextcol    = (cyc == ackc[0]);
            alu_nextrowtop = (cyc == ackc[1]);
            alu_nextrowbot = (cyc == ackc[2]);
            mem_rdata  = prev_rd ? mem[prev_addr] : 24'($urandom);
            alu_done   = (w >= 0 && dd >= 0 && cyc == w + dd);
            alu_result = alu_done ? res : 16'($urandom);
            #1;
            chk("busy", busy, (cyc != 0));
            chk("mem_rd", mem_rd, (cyc >= 1 && cyc <= 64));
            if (cyc >= 1 && cyc <= 64) chk("mem_addr", mem_addr, cyc - 1);
            chk("alu_start", alu_start, (cyc == 66));
            prev_rd = mem_rd; prev_addr = mem_addr;
            in_feed = (cyc >= 67) && !(w >= 0 && cyc >= w);
            rdy_obs = {alu_rowbotready, alu_rowtopready, alu_colready};
            for (int s = 0; s < 3; s++) begin
                chk("ready", rdy_obs[s], (in_feed && cyc == nxt[s]));
                if (in_feed && cyc == nxt[s]) begin
                    if (s == 0 && n[0] == abort_col) abort_next = 1;
                    d = $urandom_range(3, ack_max);
                    ackc[s] = cyc + d;
                    if (n[s] == lastn[s]) begin
                        fin[s] = cyc + d; nxt[s] = -1;
                    end else begin
                        nxt[s] = cyc + d + 1;
                    end
                    n[s]++;
                end
                if (in_feed && n[s] > 0 && cyc <= ackc[s]) begin
                    obs = (s == 0) ? alu_col : (s == 1) ? {40'h0, alu_rowtop} : {40'h0, alu_rowbot};
                    chk("slice_data", obs, exp_slice(s, n[s] - 1));
                    if (special && s == 0) chk("col_pattern", alu_col, (n[0] == 13) ? 64'h400 : 64'h0);
                end
            end
            if (fin[0] >= 0 && fin[1] >= 0 && fin[2] >= 0) begin
                w = fin[0];
                if (fin[1] > w) w = fin[1];
                if (fin[2] > w) w = fin[2];
                w = w + 1;
            end
            chk("lastcol", alu_lastcol, (in_feed && n[0] >= 24));
            exp_done = (w >= 0 && dd >= 0 && dd <= 20 && cyc == w + dd + 1);
            exp_err  = (w >= 0 && (dd < 0 || dd > 20) && cyc == w + 20);
            if (exp_done) exp_result = res;
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("result", result, exp_result);
            if (exp_done || exp_err) return;
        end
        n_chk++;
        $error("FAIL job_bound: got no job end expected end within 4000 cycles");
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; mem_rdata = '0; alu_done = 1'b0; alu_result = '0;
        {alu_nextcol, alu_nextrowtop, alu_nextrowbot} = 3'b000;
        repeat (3) @(posedge clk);
        #2;
        chk_quiet("reset");
        rst = 1'b0;
        idle(3);

        fill_mem(0);
        run_job(3, 5, 16'h1A05, 0, -1, -1, 0);
        idle(2);

        fill_mem(1);
        run_job(4, 7, 16'($urandom), 0, -1, -1, 1);
        idle(1);

        fill_mem(0);
        run_job(5, -1, 16'h0, 0, -1, -1, 0);
        idle(2);

        fill_mem(0);
        run_job(3, 20, 16'hBEEF, 0, -1, -1, 0);
        fill_mem(0);
        run_job(6, 0, 16'h0123, 0, -1, -1, 0);
        idle(1);

        fill_mem(0);
        run_job(4, 3, 16'h5555, 0, 7, -1, 0);
        idle(3);
        run_job(4, 3, 16'h7777, 0, -1, -1, 0);

        run_job(4, 3, 16'h9999, 0, -1, 30, 0);
        idle(2);
        fill_mem(0);
        run_job(3, 2, 16'h3C3C, 0, -1, -1, 0);

        for (int j = 0; j < 3; j++) begin
            fill_mem(0);
            run_job(3, j + 1, 16'($urandom), 1, -1, -1, 0);
        end
        idle(2);

        for (int j = 0; j < 4; j++) begin
            fill_mem(0);
            run_job(6, $urandom_range(0, 15), 16'($urandom), 0, -1, -1, 0);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cmp_sequencer.md
CMP_SEQUENCER -- requirements
Module: cmp_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 255, meaning max cycles in WAIT_DONE before abort.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  1  start a job; sampled only in IDLE.
REQ-005 mem_rd  output  1  read strobe to bitmap row memory.
REQ-006 mem_addr  output  6  row index 0..63 (row 0 = top).
REQ-007 mem_rdata  input  24  row data, valid exactly 1 cycle after mem_rd; bit 23 = leftmost pixel (column 0).
REQ-008 alu_start  output  1  one-cycle reset pulse to compare ALU.
REQ-009 alu_col / alu_rowtop / alu_rowbot  output  64/24/24  slice data to ALU.
REQ-010 alu_colready / alu_rowtopready / alu_rowbotready  output  1 each  one-cycle load strobes.
REQ-011 alu_lastcol  output  1  high while column 23 is presented.
REQ-012 alu_nextcol / alu_nextrowtop / alu_nextrowbot  input  1 each  ALU "slice checked" flags.
REQ-013 alu_done  input  1; alu_result  input  16.
REQ-014 busy  output  1; done  output  1 (one-cycle pulse); err  output  1 (one-cycle pulse); result  output  16.

Function
REQ-015 FSM states IDLE, LOAD, INIT, FEED, WAIT_DONE, FINISH; encoding free.
REQ-016 IDLE: req=1 -> LOAD, clear row counter; busy=1 in every state except IDLE.
REQ-017 LOAD: mem_rd=1 with mem_addr 0..63 on consecutive cycles; each mem_rdata is written to internal buffer entry (addr of previous cycle); LOAD lasts 65 cycles (64 reads + 1 capture), then INIT.
REQ-018 INIT: alu_start=1 for exactly one cycle, clear column index c, top index t, bottom index b; next state FEED.
REQ-019 Column c (0..23) SHALL be built so alu_col bit r = buffer[r] bit (23-c).
REQ-020 Top stream presents rows t=0..31 on alu_rowtop; bottom stream presents rows 63 down to 32 on alu_rowbot.
REQ-021 Each of the three streams runs independently: drive data, pulse its ready for one cycle, wait a 2-cycle guard, then advance on the first cycle its alu_next* flag is 1; data held stable from ready pulse until advance.
REQ-022 The first slice of each stream SHALL be issued in the cycle after INIT.
REQ-023 alu_lastcol=1 from the ready pulse of column 23 until FEED exits.
REQ-024 Stream complete when its last slice (column 23, row 31, row 32) has been acknowledged; FEED -> WAIT_DONE when all three complete.
REQ-025 WAIT_DONE: 8-bit cycle counter from 0; alu_done=1 -> FINISH, latch result<=alu_result; counter reaching TIMEOUT first -> err pulse, return to IDLE, result unchanged.
REQ-026 FINISH: done=1 for one cycle, then IDLE; alu_done and timeout in the same cycle -> alu_done wins.
REQ-027 req while not IDLE is ignored; req held high in IDLE after FINISH starts a new job next cycle.
REQ-028 All ready/strobe outputs are 0 in IDLE, LOAD, WAIT_DONE, FINISH.

Reset
REQ-029 rst=1 in any state -> IDLE next cycle; busy, done, err, mem_rd, alu_start, all ready strobes, alu_lastcol = 0; result=16'h0000; counters cleared; buffer contents need not clear.
REQ-030 rst during LOAD/FEED abandons the job; no done or err pulse is produced.

Verification
REQ-031 Reset then req pulse -> mem_rd high 64 cycles, addr 0..63, alu_start one pulse exactly 65 cycles after LOAD entry.
REQ-032 Buffer with only row 10 = 24'h000800 -> column 12 presented with alu_col = 64'h400; all other columns zero.
REQ-033 ALU model acks each slice 3 cycles after ready, alu_done with result 16'h1A05 -> result=16'h1A05, single done pulse, busy falls the cycle after.
REQ-034 ALU model never asserts alu_done, TIMEOUT=20 -> err pulse 20 cycles into WAIT_DONE, result stays 0, back to IDLE.
REQ-035 rst asserted during column 7 feed -> next cycle all outputs at reset values; subsequent req runs a complete clean job.
REQ-036 req held high continuously -> back-to-back jobs, each with exactly one done pulse and one alu_start pulse.
